event_encoder: RTL

EVENT_ENCODER -- requirements
Module: event_encoder

---
 rtl/event_encoder.sv | 72 +++++++
 1 files changed

// File: rtl/event_encoder.sv
// Eight-line event capture with a fixed-priority index encoder and valid/ready handoff.
// Pending events accumulate until the consumer accepts their index; re-events on pending lines set a sticky overflow.
module event_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i,
    input  logic       ready,
    output logic [2:0] o,
    output logic       valid,
    output logic [7:0] pend,
    output logic       ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_o;
    logic [7:0] r_pend;
    logic       r_ovf;

    logic       w_accept;
    logic [7:0] w_clr;
    logic [7:0] w_rem;
    logic [2:0] w_pick;

    // Line 0 wins: scan from the top so the lowest set bit is written last.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int n = 7; n >= 0; n--) begin
            if (v[n]) idx = 3'(n);
        end
        return idx;
    endfunction

    assign w_accept = (r_state == OFFER) && ready;
    assign w_clr    = w_accept ? (8'd1 << r_o) : 8'd0;
    // Only events already registered compete for the next offer.
    assign w_rem    = r_pend & ~w_clr;
    assign w_pick   = lowest_set(w_rem);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_o     <= 3'd0;
            r_pend  <= 8'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_pend <= w_rem | i;
            if (|(i & w_rem)) r_ovf <= 1'b1;
            if (r_state == IDLE || w_accept) begin
                if (|w_rem) begin
                    r_state <= OFFER;
                    r_o     <= w_pick;
                end else begin
                    r_state <= IDLE;
                    r_o     <= 3'd0;
                end
            end
        end
    end

    assign o     = r_o;
    assign valid = (r_state == OFFER);
    assign pend  = r_pend;
    assign ovf   = r_ovf;

endmodule
